// File: rtl/graph_mem_arbiter.sv
// graph_mem_arbiter: round-robin sharing of one graph_memory port among NUM_REQ requesters,
// with an in-order tag FIFO that steers each memory response back to its issuer.
module graph_mem_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [NUM_REQ-1:0]            resp_valid_out,
  output logic [DATA_WIDTH-1:0]         resp_data_out,
  output logic                          mem_valid_out,
  output logic [ADDR_WIDTH-1:0]         mem_req_out,
  input  logic                          mem_valid_in,
  input  logic [DATA_WIDTH-1:0]         mem_data_in,
  output logic                          busy_out,
  output logic                          err_out
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int FW = $clog2(MAX_INFLIGHT);
  localparam int CW = FW + 1;

  logic [PW-1:0]         ptr_q, ptr_d, off, gnt_idx;
  logic [PW:0]           sum;
  logic [2*NUM_REQ-1:0]  dbl;
  logic [NUM_REQ-1:0]    rot;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [PW-1:0]         tag_q [MAX_INFLIGHT];
  logic [FW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  push, pop;
  logic                  mem_valid_q, busy_q, err_q;
  logic [ADDR_WIDTH-1:0] mem_req_q;
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  // Rotate valids so bit 0 is the pointer's requester; lowest set bit wins.
  assign dbl = {req_valid_in, req_valid_in} >> ptr_q;
  assign rot = dbl[NUM_REQ-1:0];

  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = PW'(k);
  end

  assign sum     = {1'b0, ptr_q} + {1'b0, off};
  assign gnt_idx = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
  assign ptr_d   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign push    = (|rot) && (cnt_q < CW'(MAX_INFLIGHT));
  assign pop     = mem_valid_in && (cnt_q != '0);
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

  assign req_ready_out = push ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_idx == PW'(i)) gnt_addr = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_ff @(posedge clk_in)
    if (push) tag_q[wr_q] <= gnt_idx;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_req_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mem_valid_q  <= push;
      resp_valid_q <= pop ? (NUM_REQ'(1) << tag_q[rd_q]) : '0;
      cnt_q        <= cnt_d;
      busy_q       <= cnt_d != '0;
      if (push) begin
        mem_req_q <= gnt_addr;
        ptr_q     <= ptr_d;
        wr_q      <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q        <= rd_q + 1'b1;
        resp_data_q <= mem_data_in;
      end
      if (mem_valid_in && !pop) err_q <= 1'b1;
    end
  end

  assign mem_valid_out  = mem_valid_q;
  assign mem_req_out    = mem_req_q;
  assign resp_valid_out = resp_valid_q;
  assign resp_data_out  = resp_data_q;
  assign busy_out       = busy_q;
  assign err_out        = err_q;
endmodule

// File: tb/tb_graph_mem_arbiter.sv
// tb_graph_mem_arbiter: directed and random stimulus against a queue-based reference model;
// memory requests and responses are scoreboarded and checked by an independent monitor.
module tb_graph_mem_arbiter;
  localparam int N = 4, AW = 32, DW = 32, MI = 4;

  logic              clk = 1'b0;
  logic              rst_in = 1'b1;
  logic [N-1:0]      req_valid_in = '0;
  logic [N*AW-1:0]   req_addr_in = '0;
  logic [N-1:0]      req_ready_out, resp_valid_out;
  logic [DW-1:0]     resp_data_out, mem_data_in = '0;
  logic              mem_valid_out, mem_valid_in = 1'b0, busy_out, err_out;
  logic [AW-1:0]     mem_req_out;

  graph_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_INFLIGHT(MI)) dut (
    .clk_in(clk), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_addr_in(req_addr_in),
    .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out),
    .mem_valid_out(mem_valid_out), .mem_req_out(mem_req_out), .mem_valid_in(mem_valid_in),
    .mem_data_in(mem_data_in), .busy_out(busy_out), .err_out(err_out));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [AW-1:0] addr;} mem_e_t;
  typedef struct {int cyc; logic [N-1:0] who; logic [DW-1:0] data;} resp_e_t;
  typedef struct {int tag; logic [AW-1:0] addr; int gc;} fl_e_t;

  mem_e_t  exp_mem[$];
  resp_e_t exp_resp[$];
  fl_e_t   inflight[$];
  int      ptr = 0;
  bit      err_m = 0, armed = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic [AW-1:0] addr[N];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  function automatic logic [N-1:0] exp_ready(input logic [N-1:0] rv);
    if (inflight.size() >= MI) return '0;
    for (int k = 0; k < N; k++)
      if (rv[(ptr + k) % N]) return N'(1) << ((ptr + k) % N);
    return '0;
  endfunction

  // mm: 0 = memory silent, 1 = answer oldest once lat cycles past mem_valid_out,
  //     2 = answer now if anything is in flight (lat 1), else a spurious strobe
  task automatic step(input logic [N-1:0] rv, input int mm, input int lat, input bit rst);
    logic [N-1:0] g;
    fl_e_t f;
    mem_e_t me;
    resp_e_t re;
    @(posedge clk);
    #1;
    rst_in = rst;
    req_valid_in = rv;
    for (int i = 0; i < N; i++) req_addr_in[i*AW +: AW] = addr[i];
    mem_valid_in = 1'b0;
    mem_data_in = $urandom;
    if (!rst) begin
      if (mm == 2 && inflight.size() == 0) mem_valid_in = 1'b1;
      else if (mm != 0 && inflight.size() > 0 &&
               inflight[0].gc + 1 + (mm == 2 ? 1 : lat) <= cyc) begin
        mem_valid_in = 1'b1;
        mem_data_in = inflight[0].addr + 100;
      end
    end
    @(negedge clk);
    g = exp_ready(rv);
    if (armed) begin
      chk("ready", req_ready_out, g);
      chk("busy", busy_out, inflight.size() != 0);
      chk("err", err_out, err_m);
      chk("mem_req_hold", mem_req_out, last_addr);
      chk("resp_data_hold", resp_data_out, last_data);
    end
    if (rst) begin
      ptr = 0; err_m = 0; last_addr = '0; last_data = '0;
      inflight.delete();
      while (exp_mem.size() > 0 && exp_mem[$].cyc > cyc) void'(exp_mem.pop_back());
      while (exp_resp.size() > 0 && exp_resp[$].cyc > cyc) void'(exp_resp.pop_back());
    end else begin
      if (mem_valid_in) begin
        if (inflight.size() > 0) begin
          f = inflight.pop_front();
          re.cyc = cyc + 1; re.who = N'(1) << f.tag; re.data = mem_data_in;
          exp_resp.push_back(re);
          last_data = mem_data_in;
        end else err_m = 1;
      end
      for (int i = 0; i < N; i++) if (g[i]) begin
        f.tag = i; f.addr = addr[i]; f.gc = cyc;
        inflight.push_back(f);
        me.cyc = cyc + 1; me.addr = addr[i];
        exp_mem.push_back(me);
        last_addr = addr[i];
        ptr = (i + 1) % N;
      end
    end
  endtask

  mem_e_t  mon_m;
  resp_e_t mon_r;
  bit      due;

  always @(negedge clk) if (armed) begin
    due = exp_mem.size() > 0 && exp_mem[0].cyc <= cyc;
    if (mem_valid_out || due) begin
      if (exp_mem.size() == 0) chk("mem_unexpected", mem_valid_out, 1'b0);
      else begin
        mon_m = exp_mem.pop_front();
        chk("mem_when", mem_valid_out ? 64'(cyc) : '1, 64'(mon_m.cyc));
        chk("mem_addr", mem_req_out, mon_m.addr);
      end
    end
    due = exp_resp.size() > 0 && exp_resp[0].cyc <= cyc;
    if (resp_valid_out != '0 || due) begin
      if (exp_resp.size() == 0) chk("resp_unexpected", resp_valid_out, '0);
      else begin
        mon_r = exp_resp.pop_front();
        chk("resp_when", resp_valid_out != '0 ? 64'(cyc) : '1, 64'(mon_r.cyc));
        chk("resp_who", resp_valid_out, mon_r.who);
        chk("resp_data", resp_data_out, mon_r.data);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && inflight.size() > 0; i++) step('0, 1, 1, 0);
    repeat (3) step('0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) addr[i] = '0;
    step('0, 0, 0, 1);
    armed = 1;
    step('0, 0, 0, 1);
    step('0, 0, 0, 0);
    // single request, memory latency 2
    addr[1] = 1;
    step(4'b0010, 1, 2, 0);
    repeat (6) step('0, 1, 2, 0);
    // round-robin fairness
    for (int i = 0; i < N; i++) addr[i] = 10 + i;
    repeat (12) step(4'b1111, 1, 2, 0);
    drain();
    // FIFO full with memory stalled, then one release
    repeat (8) step(4'b0001, 0, 0, 0);
    step(4'b0001, 2, 0, 0);
    repeat (3) step(4'b0001, 0, 0, 0);
    drain();
    // pointer skip: park pointer at 2, then only 1 and 3 valid
    step(4'b0010, 1, 1, 0);
    repeat (3) step(4'b1010, 1, 1, 0);
    drain();
    // spurious response, sticky error, cleared by reset
    step('0, 2, 0, 0);
    repeat (3) step('0, 0, 0, 0);
    step('0, 0, 0, 1);
    step('0, 0, 0, 0);
    // reset with three requests outstanding
    repeat (3) step(4'b0111, 0, 0, 0);
    step('0, 0, 0, 1);
    step(4'b1111, 1, 1, 0);
    drain();
    // random traffic
    repeat (600) begin
      int r;
      logic [N-1:0] rv;
      for (int i = 0; i < N; i++) addr[i] = $urandom;
      r = $urandom_range(0, 49);
      rv = N'($urandom);
      step(rv, r < 30 ? 1 : (r == 30 ? 2 : 0), $urandom_range(1, 3), $urandom_range(0, 99) == 0);
    end
    drain();
    chk("drain_inflight", inflight.size(), 0);
    chk("scoreboard_empty", exp_mem.size() + exp_resp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
